// File: rtl/led_pkg.sv
// rtl/led_pkg.sv - shared mode codes, entry patterns and speed width for led_mode_ctrl
package led_pkg;

    typedef enum logic [2:0] {
        MODE_OFF    = 3'd0,
        MODE_RIGHT  = 3'd1,
        MODE_LEFT   = 3'd2,
        MODE_BOUNCE = 3'd3,
        MODE_BLINK  = 3'd4
    } mode_t;

    localparam int SPD_W = 2;

    localparam logic [3:0] LED_OFF_ENTRY    = 4'b0000;
    localparam logic [3:0] LED_RIGHT_ENTRY  = 4'b0001;
    localparam logic [3:0] LED_LEFT_ENTRY   = 4'b0001;
    localparam logic [3:0] LED_BOUNCE_ENTRY = 4'b0001;
    localparam logic [3:0] LED_BLINK_ENTRY  = 4'b1111;

    // Unreachable codes 5-7 fall back to RIGHT.
    function automatic mode_t next_mode(input mode_t m);
        case (m)
            MODE_OFF:    next_mode = MODE_RIGHT;
            MODE_RIGHT:  next_mode = MODE_LEFT;
            MODE_LEFT:   next_mode = MODE_BOUNCE;
            MODE_BOUNCE: next_mode = MODE_BLINK;
            MODE_BLINK:  next_mode = MODE_OFF;
            default:     next_mode = MODE_RIGHT;
        endcase
    endfunction

    function automatic logic [3:0] entry_led(input mode_t m);
        case (m)
            MODE_OFF:    entry_led = LED_OFF_ENTRY;
            MODE_RIGHT:  entry_led = LED_RIGHT_ENTRY;
            MODE_LEFT:   entry_led = LED_LEFT_ENTRY;
            MODE_BOUNCE: entry_led = LED_BOUNCE_ENTRY;
            MODE_BLINK:  entry_led = LED_BLINK_ENTRY;
            default:     entry_led = LED_RIGHT_ENTRY;
        endcase
    endfunction

endpackage

// File: rtl/key_debounce.sv
// rtl/key_debounce.sv - 2-FF synchroniser, debounce counter and single press pulse for an active-low key
module key_debounce #(
    parameter int DEB_CYCLES = 20
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key,
    output logic press
);

    localparam int CW = $clog2(DEB_CYCLES + 1);

    logic          sync1;
    logic          sync2;
    logic [CW-1:0] cnt;

    // cnt saturates at DEB_CYCLES so a held key yields exactly one pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
            cnt   <= '0;
            press <= 1'b0;
        end else begin
            sync1 <= key;
            sync2 <= sync1;
            press <= 1'b0;
            if (sync2) begin
                cnt <= '0;
            end else if (cnt != CW'(DEB_CYCLES)) begin
                cnt   <= cnt + CW'(1);
                press <= (cnt == CW'(DEB_CYCLES - 1));
            end
        end
    end

endmodule

// File: rtl/led_mode_ctrl.sv
// rtl/led_mode_ctrl.sv - key-driven LED pattern controller; optional pause key under LED_PAUSE_EN
module led_mode_ctrl
    import led_pkg::*;
#(
    parameter int BASE_DELAY = 50,
    parameter int DEB_CYCLES = 20
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       key_mode,
    input  logic       key_speed,
`ifdef LED_PAUSE_EN
    input  logic       key_pause,
`endif
    output logic [3:0] led,
    output logic [2:0] mode,
    output logic       tick
);

    mode_t            mode_r;
    logic [SPD_W-1:0] spd;
    logic [31:0]      cnt;
    logic [31:0]      period;
    logic             dir_up;
    logic             paused;
    logic             mode_press;
    logic             speed_press;
    logic [3:0]       bounce_nxt;

    key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_mode (
        .clk   (clk),
        .rst_n (rst_n),
        .key   (key_mode),
        .press (mode_press)
    );

    key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_speed (
        .clk   (clk),
        .rst_n (rst_n),
        .key   (key_speed),
        .press (speed_press)
    );

`ifdef LED_PAUSE_EN
    logic pause_press;

    key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_pause (
        .clk   (clk),
        .rst_n (rst_n),
        .key   (key_pause),
        .press (pause_press)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            paused <= 1'b0;
        end else if (mode_press) begin
            paused <= 1'b0;
        end else if (pause_press) begin
            paused <= ~paused;
        end
    end
`else
    assign paused = 1'b0;
`endif

    assign period = 32'(BASE_DELAY) << spd;
    assign tick   = !paused && (cnt == period - 32'd1);
    assign mode   = mode_r;

    always_comb begin
        bounce_nxt = dir_up ? {led[2:0], 1'b0} : {1'b0, led[3:1]};
    end

    // A mode press outranks a coincident tick: the entry value wins, no step.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_r <= MODE_RIGHT;
            led    <= LED_RIGHT_ENTRY;
            spd    <= '0;
            cnt    <= '0;
            dir_up <= 1'b1;
        end else begin
            if (speed_press) begin
                spd <= spd + SPD_W'(1);
            end
            if (mode_press) begin
                mode_r <= next_mode(mode_r);
                led    <= entry_led(next_mode(mode_r));
                dir_up <= 1'b1;
                cnt    <= '0;
            end else if (tick) begin
                cnt <= '0;
                case (mode_r)
                    MODE_OFF:   led <= LED_OFF_ENTRY;
                    MODE_RIGHT: led <= {led[0], led[3:1]};
                    MODE_LEFT:  led <= {led[2:0], led[3]};
                    MODE_BOUNCE: begin
                        if (bounce_nxt == 4'b0000) begin
                            led    <= LED_BOUNCE_ENTRY;
                            dir_up <= 1'b1;
                        end else begin
                            led <= bounce_nxt;
                            if (bounce_nxt == 4'b1000) begin
                                dir_up <= 1'b0;
                            end else if (bounce_nxt == 4'b0001) begin
                                dir_up <= 1'b1;
                            end
                        end
                    end
                    MODE_BLINK: led <= (led == 4'b1111) ? 4'b0000 : 4'b1111;
                    default: begin
                        mode_r <= MODE_RIGHT;
                        led    <= LED_RIGHT_ENTRY;
                    end
                endcase
            end else if (speed_press) begin
                cnt <= '0;
            end else if (!paused) begin
                cnt <= cnt + 32'd1;
            end
        end
    end

endmodule

// File: doc/led_mode_ctrl.md
LED_MODE_CTRL -- requirements
Module: led_mode_ctrl

Interface
REQ-001 SHALL have parameter BASE_DELAY, default 50, meaning tick period in clk cycles at speed level 0 (legal minimum 2).
REQ-002 SHALL have parameter DEB_CYCLES, default 20, meaning consecutive stable-low cycles required to accept a key press.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port key_mode, input, 1 bit: raw mode key, active-low, asynchronous to clk.
REQ-006 SHALL have port key_speed, input, 1 bit: raw speed key, active-low, asynchronous to clk.
REQ-007 SHALL have port key_pause, input, 1 bit: raw pause key, active-low; present only under LED_PAUSE_EN.
REQ-008 SHALL have port led, output, 4 bits: LED drive, registered.
REQ-009 SHALL have port mode, output, 3 bits: current mode code, registered.
REQ-010 SHALL have port tick, output, 1 bit: one-cycle pulse marking each pattern step.

Function
REQ-011 SHALL synchronise each key through 2 flip-flops, then debounce it.
REQ-012 SHALL emit a one-cycle press pulse per key when the synchronised level has been low for DEB_CYCLES consecutive cycles.
REQ-013 SHALL emit at most one pulse per press, with no repeat while the key stays held; any high sample SHALL restart the debounce count.
REQ-014 SHALL encode modes as OFF=0, RIGHT=1, LEFT=2, BOUNCE=3, BLINK=4; codes 5-7 are unreachable and SHALL recover to RIGHT.
REQ-015 SHALL advance the mode on each mode press in the order OFF->RIGHT->LEFT->BOUNCE->BLINK->OFF.
REQ-016 SHALL hold a 2-bit speed level spd, incremented on each speed press and wrapping 3->0; tick period = BASE_DELAY << spd.
REQ-017 SHALL use a 32-bit tick counter cnt counting 0..period-1, with tick=1 only in the cycle cnt==period-1, after which cnt returns to 0.
REQ-018 SHALL, on each tick, step led as follows:
- OFF: hold 0000.
- RIGHT: rotate right, {led[0],led[3:1]}.
- LEFT: rotate left, {led[2:0],led[3]}.
- BOUNCE: ping-pong 0001,0010,0100,1000,0100,0010,0001,... with the direction flag reversing at 1000 and at 0001.
- BLINK: toggle between 1111 and 0000.
REQ-019 SHALL, in the cycle after a mode press, load the entry value (OFF 0000, RIGHT 0001, LEFT 0001, BOUNCE 0001 moving up, BLINK 1111) and clear cnt.
REQ-020 SHALL clear cnt in the cycle after a speed press while leaving led unchanged.
REQ-021 SHALL apply both changes and clear cnt once when a mode press and a speed press occur in the same cycle.
REQ-022 SHALL give a mode press priority over a coincident tick: the entry value is loaded and no step occurs.

Reset
REQ-023 SHALL, on rst_n low, immediately set mode=RIGHT, led=0001, spd=0, cnt=0, tick=0, BOUNCE direction=up, paused=0, and all debounce counters and synchronisers to the idle (key-released) state.
REQ-024 SHALL, when reset is asserted mid-pattern, abandon the pattern with no residual state; the first tick after release SHALL occur BASE_DELAY cycles later.

Configuration
REQ-025 SHALL, with macro LED_PAUSE_EN defined, add key_pause: each pause press toggles paused, and while paused cnt and led hold and tick stays 0.
REQ-026 SHALL, under LED_PAUSE_EN, clear paused on a mode press, and SHALL apply speed presses while paused.
REQ-027 SHALL, without LED_PAUSE_EN, omit the key_pause port and its debouncer and never pause.

Structure
REQ-028 SHALL place the mode enum/codes, entry-pattern constants and the speed-level width in shared package led_pkg.
REQ-029 SHALL instantiate one sub-module, key_debounce (synchroniser plus debounce plus press pulse, parameter DEB_CYCLES), once per key.

Verification (BASE_DELAY=4, DEB_CYCLES=3)
REQ-030 SHALL cover: release reset -> mode=1, led=0001; ticks at cycles 4, 8 and 12 -> led 1000, 0100, 0010.
REQ-031 SHALL cover: key_mode low for 5 cycles -> exactly one press; mode=2, led=0001, then 0010 on the next tick, 4 cycles later.
REQ-032 SHALL cover: key_mode low for 2 cycles only -> no press; mode and led unchanged.
REQ-033 SHALL cover: BOUNCE over 8 ticks -> led sequence 0001,0010,0100,1000,0100,0010,0001,0010.
REQ-034 SHALL cover: 4 successive speed presses -> measured tick spacing 8, 16, 32, then 4 cycles.
REQ-035 SHALL cover: rst_n pulled low asynchronously mid-BLINK -> led=0001 and mode=1 before the next clk edge.
